// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: RISC-V rounding-mode encodings.
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

endpackage

// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result valid-ready bundle for the significand add/sub pipeline.
interface fpu_addsub_pipe_if #(
   parameter int WIDTH = 48,
   parameter int TAG_W = 5
);
   localparam int LZC_W = $clog2(WIDTH + 2);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             sign_a;
   logic             effective_sub;
   logic             sticky_in;
   logic [2:0]       rm;
   logic [TAG_W-1:0] tag_in;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   sum;
   logic             result_sign;
   logic             guard;
   logic             round;
   logic             sticky;
   logic [LZC_W-1:0] lzc;
   logic             zero;
   logic [TAG_W-1:0] tag_out;

   modport master (
      output in_valid, operand_a, operand_b, sign_a, effective_sub, sticky_in, rm, tag_in,
      output out_ready,
      input  in_ready,
      input  out_valid, sum, result_sign, guard, round, sticky, lzc, zero, tag_out
   );

   modport slave (
      input  in_valid, operand_a, operand_b, sign_a, effective_sub, sticky_in, rm, tag_in,
      input  out_ready,
      output in_ready,
      output out_valid, sum, result_sign, guard, round, sticky, lzc, zero, tag_out
   );
endinterface

// File: rtl/fpu_lzc.sv
// Leading-zero counter; returns W when the input is all zeros.
module fpu_lzc #(
   parameter int W  = 49,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] cnt
);
   // Scan upward so the most significant set bit has the final say.
   always_comb begin
      cnt = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (din[i]) cnt = CW'(W - 1 - i);
      end
   end
endmodule

// File: rtl/fpu_addsub_pipe.sv
// Two-stage significand add/sub: S1 magnitude+sign, S2 GRS/lzc/zero; latency 2.
// Valid-ready; holds S1+S2 (2 ops) under backpressure, flush/rst drop all in flight.
module fpu_addsub_pipe
   import fpu_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   fpu_addsub_pipe_if.slave io
);
   localparam int LZC_W = $clog2(WIDTH + 2);

   logic             s1_valid, s2_valid;
   logic             s1_adv, s2_adv, accept;
   logic [WIDTH:0]   a_ext, b_ext, sum_c;
   logic             sign_c, a_wins;

   logic [WIDTH:0]   s1_sum;
   logic             s1_sign, s1_sticky;
   logic [TAG_W-1:0] s1_tag;

   logic [LZC_W-1:0] lzc_c;
   logic [WIDTH:0]   s2_sum;
   logic             s2_sign, s2_guard, s2_round, s2_sticky, s2_zero;
   logic [LZC_W-1:0] s2_lzc;
   logic [TAG_W-1:0] s2_tag;

   assign s2_adv      = !s2_valid || io.out_ready;
   assign s1_adv      = s1_valid && s2_adv;
   assign io.in_ready = !s1_valid || s2_adv;
   assign accept      = io.in_valid && io.in_ready;

   // Ties with sticky bits lost from b mean b was really the larger magnitude.
   always_comb begin
      a_ext  = {1'b0, io.operand_a};
      b_ext  = {1'b0, io.operand_b};
      a_wins = (io.operand_a > io.operand_b) ||
               ((io.operand_a == io.operand_b) && !io.sticky_in);
      sum_c  = a_ext + b_ext;
      sign_c = io.sign_a;
      if (io.effective_sub) begin
         if (a_wins) begin
            sum_c = a_ext - b_ext - {{WIDTH{1'b0}}, io.sticky_in};
         end else begin
            sum_c  = b_ext - a_ext;
            sign_c = !io.sign_a;
         end
         if ((sum_c == '0) && !io.sticky_in) sign_c = (io.rm == RM_RDN);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_adv) s2_valid <= s1_valid;
         if (accept) s1_valid <= 1'b1;
         else if (s1_adv) s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_sum    <= sum_c;
         s1_sign   <= sign_c;
         s1_sticky <= io.sticky_in;
         s1_tag    <= io.tag_in;
      end
   end

   fpu_lzc #(.W(WIDTH + 1), .CW(LZC_W)) u_lzc (
      .din (s1_sum),
      .cnt (lzc_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_sum    <= '0;
         s2_sign   <= 1'b0;
         s2_guard  <= 1'b0;
         s2_round  <= 1'b0;
         s2_sticky <= 1'b0;
         s2_zero   <= 1'b0;
         s2_lzc    <= '0;
         s2_tag    <= '0;
      end else if (s1_adv) begin
         s2_sum    <= s1_sum;
         s2_sign   <= s1_sign;
         s2_guard  <= s1_sum[2];
         s2_round  <= s1_sum[1];
         s2_sticky <= s1_sum[0] | s1_sticky;
         s2_zero   <= (s1_sum == '0) && !s1_sticky;
         s2_lzc    <= lzc_c;
         s2_tag    <= s1_tag;
      end
   end

   assign io.out_valid   = s2_valid;
   assign io.sum         = s2_sum;
   assign io.result_sign = s2_sign;
   assign io.guard       = s2_guard;
   assign io.round       = s2_round;
   assign io.sticky      = s2_sticky;
   assign io.lzc         = s2_lzc;
   assign io.zero        = s2_zero;
   assign io.tag_out     = s2_tag;
endmodule

// File: doc/fpu_addsub_pipe.md
FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 48, meaning significand operand width (>=8).
REQ-002 SHALL have parameter TAG_W, default 5, meaning width of the pass-through tag (e.g. destination register).
REQ-003 SHALL derive local parameter LZC_W = clog2(WIDTH+2).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset; flush in 1 drop all in-flight ops.
REQ-005 SHALL have ports: in_valid in 1; in_ready out 1; operand_a in WIDTH larger/product operand; operand_b in WIDTH aligned addend; sign_a in 1 sign of operand_a; effective_sub in 1; sticky_in in 1 bits shifted out of operand_b; rm in 3 RISC-V rounding mode; tag_in in TAG_W.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; sum out WIDTH+1 magnitude; result_sign out 1; guard out 1; round out 1; sticky out 1; lzc out LZC_W leading zeros of sum; zero out 1 exact zero; tag_out out TAG_W.

Function
REQ-007 SHALL be a two-stage pipeline: S1 registers add/sub magnitude, sign, sticky; S2 registers GRS, lzc, zero; latency 2 cycles with no stall.
REQ-008 SHALL accept an op when in_valid && in_ready.
REQ-009 SHALL advance S2 when !s2_valid || out_ready; SHALL advance S1 into S2 when s1_valid && S2 advances.
REQ-010 SHALL drive in_ready = !s1_valid || (S2 advances), combinationally; full throughput 1 op/cycle when out_ready=1.
REQ-011 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-012 SHALL preserve op order; no op dropped or duplicated under any valid/ready pattern.
REQ-013 Addition: sum = a + b (WIDTH+1 bits, carry in MSB), result_sign = sign_a.
REQ-014 Subtraction, a > b, or a == b && !sticky_in: sum = a - b - sticky_in, result_sign = sign_a.
REQ-015 Subtraction otherwise: sum = b - a (no borrow), result_sign = !sign_a.
REQ-016 guard = sum[2], round = sum[1], sticky = sum[0] | sticky_in.
REQ-017 lzc = count of leading zeros of the WIDTH+1-bit sum; lzc = WIDTH+1 when sum == 0.
REQ-018 zero = (sum == 0) && !sticky_in.
REQ-019 When zero and effective_sub: result_sign = 1 if rm == RDN, else 0; when zero and addition: result_sign = sign_a.
REQ-020 tag_in SHALL travel with its op to tag_out unchanged.
REQ-021 flush SHALL clear s1_valid and s2_valid next edge and take priority over a simultaneous accept; the input op presented that cycle SHALL be discarded.

Reset
REQ-022 On rst: s1_valid = s2_valid = 0, out_valid = 0, sum/lzc/tag_out/flags = 0; in_ready = 1 the cycle after reset deasserts.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight ops; no out_valid until a new op is accepted after reset.

Structure
REQ-024 Rounding-mode constants (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100) SHALL reside in shared package fpu_pkg.
REQ-025 Leading-zero count SHALL be a sub-module fpu_lzc parametrised by input width.
REQ-026 Datapath registers SHALL be enable-gated by stage-advance only; no reset needed on data in synthesis beyond REQ-022 values.

Verification (WIDTH=8)
REQ-027 a=0x80,b=0x01,sub,s=0,sign_a=0 -> sum=0x07F, sign=0, lzc=2, G=1,R=1,S=1, two cycles later.
REQ-028 a=0xFF,b=0xFF,add -> sum=0x1FE, lzc=0, G=1,R=1,S=0; a=0x10,b=0x01,sub,s=1 -> sum=0x00E, sign=sign_a, S=1.
REQ-029 a=0x01,b=0x10,sub,s=0,sign_a=0 -> sum=0x00F, sign=1; a=b=0x22,sub,s=1 -> sum=0, zero=0, sign=!sign_a, S=1.
REQ-030 a=b=0x55,sub,s=0: rm=RDN -> zero=1, sign=1; rm=RNE -> zero=1, sign=0.
REQ-031 Continuous in_valid, out_ready low 3 cycles -> in_ready low after 2 ops buffered; all ops emerge in order with matching tags.
REQ-032 flush (and separately rst) with 2 ops in flight and a third presented -> no out_valid for any of them; next op accepted completes normally.
